// File: rtl/rv_dmem_resp_pkg.sv
// rtl/rv_dmem_resp_pkg.sv - funct3 encodings and FSM state type for the data-memory responder
package rv_dmem_resp_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Encodings with no meaning: 111 always, and unsigned forms used as stores.
    function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
        return (funct3 == 3'b111) || (we && funct3[2]);
    endfunction

endpackage

// File: rtl/rv_dmem_resp_if.sv
// rtl/rv_dmem_resp_if.sv - load/store request and response channels between MEM stage and responder
interface rv_dmem_resp_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [63:0] req_addr_i;
    logic [2:0]  req_funct3_i;
    logic [63:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_funct3_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_funct3_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/rv_dmem_lane.sv
// rtl/rv_dmem_lane.sv - byte-lane enables, store alignment, misalign detection and load extension
module rv_dmem_lane
    import rv_dmem_resp_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata_raw,
    output logic [7:0]  be,
    output logic [63:0] wdata_sh,
    output logic        misalign,
    output logic [63:0] rdata_ext
);

    logic [7:0]  be_base;
    logic [63:0] rdata_sh;

    always_comb begin
        be_base   = 8'h01;
        misalign  = 1'b0;
        rdata_ext = 64'd0;
        case (funct3[1:0])
            2'b00: be_base = 8'h01;
            2'b01: begin be_base = 8'h03; misalign = addr_lo[0];          end
            2'b10: begin be_base = 8'h0f; misalign = |addr_lo[1:0];       end
            default: begin be_base = 8'hff; misalign = |addr_lo;          end
        endcase

        be       = be_base << addr_lo;
        wdata_sh = wdata << {addr_lo, 3'b000};
        rdata_sh = rdata_raw >> {addr_lo, 3'b000};

        case (funct3)
            F3_B:    rdata_ext = {{56{rdata_sh[7]}},  rdata_sh[7:0]};
            F3_H:    rdata_ext = {{48{rdata_sh[15]}}, rdata_sh[15:0]};
            F3_W:    rdata_ext = {{32{rdata_sh[31]}}, rdata_sh[31:0]};
            F3_D:    rdata_ext = rdata_sh;
            F3_BU:   rdata_ext = {56'd0, rdata_sh[7:0]};
            F3_HU:   rdata_ext = {48'd0, rdata_sh[15:0]};
            F3_WU:   rdata_ext = {32'd0, rdata_sh[31:0]};
            default: rdata_ext = 64'd0;
        endcase
    end

endmodule

// File: rtl/rv_dmem_resp.sv
// rtl/rv_dmem_resp.sv - MEM-stage data-memory responder with wait states and byte-lane access
module rv_dmem_resp
    import rv_dmem_resp_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    rv_dmem_resp_if.slave bus
);

    state_t                state, state_nxt;
    logic [3:0]            wait_cnt;
    logic                  we_q;
    logic [63:0]           addr_q;
    logic [2:0]            f3_q;
    logic [63:0]           wdata_q;
    logic [63:0]           rdata_q;
    logic                  err_q;

    logic [63:0]           mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [63:0]           word_raw;
    logic [7:0]            be;
    logic [63:0]           wdata_sh;
    logic [63:0]           rdata_ext;
    logic                  misalign;
    logic                  out_of_range;
    logic                  err_now;
    logic                  accept;
    logic                  wait_done;

    assign word_idx     = addr_q[DEPTH_LOG2+2:3];
    assign word_raw     = mem[word_idx];
    assign out_of_range = |(addr_q >> (DEPTH_LOG2 + 3));
    assign err_now      = misalign || out_of_range || f3_illegal(we_q, f3_q);
    assign accept       = bus.req_valid_i && bus.req_ready_o;
    assign wait_done    = (wait_cnt == 4'(WAIT_CYCLES - 1));

    rv_dmem_lane u_lane (
        .funct3    (f3_q),
        .addr_lo   (addr_q[2:0]),
        .wdata     (wdata_q),
        .rdata_raw (word_raw),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .misalign  (misalign),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Ready is gated by rst so the core sees no acceptance while reset is held.
    always_comb begin
        state_nxt       = state;
        bus.req_ready_o = 1'b0;
        bus.rsp_valid_o = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req_ready_o = !rst;
                if (accept) state_nxt = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
            end
            S_WAIT:   if (wait_done) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_RESP;
            S_RESP: begin
                bus.rsp_valid_o = 1'b1;
                if (bus.rsp_ready_i) state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 64'd0;
            f3_q     <= 3'd0;
            wdata_q  <= 64'd0;
            rdata_q  <= 64'd0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= bus.req_we_i;
                addr_q   <= bus.req_addr_i;
                f3_q     <= bus.req_funct3_i;
                wdata_q  <= bus.req_wdata_i;
                wait_cnt <= 4'd0;
            end
            if (state == S_WAIT) wait_cnt <= wait_cnt + 4'd1;
            if (state == S_ACCESS) begin
                rdata_q <= (we_q || err_now) ? 64'd0 : rdata_ext;
                err_q   <= err_now;
            end
        end
    end

    // Array has no reset; writes only happen in ACCESS, so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && we_q && !err_now) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;

endmodule

// File: tb/tb_rv_dmem_resp.sv
// tb/tb_rv_dmem_resp.sv - directed self-checking bench for rv_dmem_resp
module tb_rv_dmem_resp;
    import rv_dmem_resp_pkg::*;

    localparam int DL2 = 10;
    localparam int WC  = 1;
    localparam int LAT = 2 + WC;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    rv_dmem_resp_if bus ();

    rv_dmem_resp #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [63:0] addr, input logic [2:0] f3,
                          input logic [63:0] wd, output logic [63:0] rd, output logic er,
                          output int lat);
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = we;
        bus.req_addr_i   = addr;
        bus.req_funct3_i = f3;
        bus.req_wdata_i  = wd;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = ~we;
        bus.req_addr_i   = 64'hdead_beef_dead_beef;
        bus.req_funct3_i = 3'b111;
        bus.req_wdata_i  = 64'h5a5a_5a5a_5a5a_5a5a;
        while (!bus.rsp_valid_o && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rd = bus.rsp_rdata_o;
        er = bus.rsp_err_o;
        @(posedge clk);
    endtask

    task automatic op(input string tag, input logic we, input logic [63:0] addr,
                      input logic [2:0] f3, input logic [63:0] wd,
                      input logic [63:0] exp_rd, input logic exp_err);
        logic [63:0] rd;
        logic        er;
        int          lat;
        do_req(we, addr, f3, wd, rd, er, lat);
        chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " err"}, 64'(er), 64'(exp_err));
        chk({tag, " latency"}, 64'(lat), 64'(LAT));
    endtask

    initial begin
        logic [63:0] held;
        logic        stable;
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_addr_i   = 64'd0;
        bus.req_funct3_i = 3'd0;
        bus.req_wdata_i  = 64'd0;
        bus.rsp_ready_i  = 1'b1;

        #12;
        chk("reset req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("reset rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("reset rdata", bus.rsp_rdata_o, 64'd0);
        chk("reset err", 64'(bus.rsp_err_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release req_ready", 64'(bus.req_ready_o), 64'd1);

        op("SD 0",  1'b1, 64'h0, F3_D, 64'h8877665544332211, 64'h0, 1'b0);
        op("LD 0",  1'b0, 64'h0, F3_D, 64'h0, 64'h8877665544332211, 1'b0);
        op("SB 3",  1'b1, 64'h3, F3_B, 64'h123456789abcdeab, 64'h0, 1'b0);
        op("LD 0 after SB", 1'b0, 64'h0, F3_D, 64'h0, 64'h88776655ab332211, 1'b0);
        op("LB 3",  1'b0, 64'h3, F3_B,  64'h0, 64'hffffffffffffffab, 1'b0);
        op("LBU 3", 1'b0, 64'h3, F3_BU, 64'h0, 64'h00000000000000ab, 1'b0);
        op("LW 4",  1'b0, 64'h4, F3_W,  64'h0, 64'hffffffff88776655, 1'b0);
        op("LWU 4", 1'b0, 64'h4, F3_WU, 64'h0, 64'h0000000088776655, 1'b0);
        op("LH 2",  1'b0, 64'h2, F3_H,  64'h0, 64'hffffffffffffab33, 1'b0);
        op("LHU 6", 1'b0, 64'h6, F3_HU, 64'h0, 64'h0000000000008877, 1'b0);
        op("LH 1 misaligned", 1'b0, 64'h1, F3_H, 64'h0, 64'h0, 1'b1);
        op("SH 1 misaligned", 1'b1, 64'h1, F3_H, 64'hffff, 64'h0, 1'b1);
        op("LD 0 untouched", 1'b0, 64'h0, F3_D, 64'h0, 64'h88776655ab332211, 1'b0);
        op("SH 6",  1'b1, 64'h6, F3_H, 64'h1234, 64'h0, 1'b0);
        op("LD 0 after SH", 1'b0, 64'h0, F3_D, 64'h0, 64'h12346655ab332211, 1'b0);

        // Response held off: outputs frozen, further requests ignored.
        bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = 1'b0;
        bus.req_addr_i   = 64'h0;
        bus.req_funct3_i = F3_D;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = 1'b1;
        bus.req_wdata_i  = 64'hcafe_cafe_cafe_cafe;
        for (int i = 0; i < 10 && !bus.rsp_valid_o; i++) @(negedge clk);
        chk("hold rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        held = bus.rsp_rdata_o;
        chk("hold rdata", held, 64'h12346655ab332211);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== held || bus.req_ready_o !== 1'b0)
                stable = 1'b0;
        end
        chk("hold stable 5 cycles", 64'(stable), 64'd1);
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("after release req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("after release rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        op("LD 0 ignored store", 1'b0, 64'h0, F3_D, 64'h0, 64'h12346655ab332211, 1'b0);

        // Reset during the wait state of a store.
        op("SD 8",  1'b1, 64'h8, F3_D, 64'h0123456789abcdef, 64'h0, 1'b0);
        op("LD 0 before abort", 1'b0, 64'h0, F3_D, 64'h0, 64'h12346655ab332211, 1'b0);
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = 1'b1;
        bus.req_addr_i   = 64'h8;
        bus.req_funct3_i = F3_D;
        bus.req_wdata_i  = 64'hffff_ffff_ffff_ffff;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("abort rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("abort rdata", bus.rsp_rdata_o, 64'd0);
        chk("abort err", 64'(bus.rsp_err_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o !== 1'b0) stable = 1'b0;
        end
        chk("abort no response", 64'(stable), 64'd1);
        op("LD 8 prior", 1'b0, 64'h8, F3_D, 64'h0, 64'h0123456789abcdef, 1'b0);

        op("SW out of range", 1'b1, 64'h1 << (DL2 + 3), F3_W, 64'h11223344, 64'h0, 1'b1);
        op("load funct3 111", 1'b0, 64'h0, 3'b111, 64'h0, 64'h0, 1'b1);
        op("SBU illegal", 1'b1, 64'h0, F3_BU, 64'hee, 64'h0, 1'b1);
        op("LD 0 after SBU", 1'b0, 64'h0, F3_D, 64'h0, 64'h12346655ab332211, 1'b0);
        op("SB top byte", 1'b1, (64'h1 << (DL2 + 3)) - 64'h1, F3_B, 64'h9c, 64'h0, 1'b0);
        op("LBU top byte", 1'b0, (64'h1 << (DL2 + 3)) - 64'h1, F3_BU, 64'h0, 64'h9c, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
